// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: reloads the core's instruction memory from a byte stream.
// While a session runs, the core is held in reset. The controller first fills
// the whole memory with NOP_WORD. It then packs incoming bytes little-endian
// into 32-bit words and writes one word per completed group of four bytes.
// When the programmed word count has been written, it releases the core.
//
// Ports:
//   CLK, RST           clock (rising edge), synchronous active-high reset
//   LOAD_START         start a session (honoured in IDLE and ERROR only)
//   LOAD_LEN           words to load; 0 -> full depth, larger values clamped
//   BYTE_IN/VALID      byte source; BYTE_READY is the accept handshake
//   MEM_WE/WADDR/WDATA instruction memory write port (one pulse per word)
//   CPU_RST            core reset hold, active-high
//   BUSY, DONE, ERR    status: session active, completion pulse, sticky timeout
module imem_load_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter logic [31:0] NOP_WORD   = 32'h00000013,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD_START,
  input  logic [DEPTH_LOG2:0]   LOAD_LEN,
  input  logic [7:0]            BYTE_IN,
  input  logic                  BYTE_VALID,
  output logic                  BYTE_READY,
  output logic                  MEM_WE,
  output logic [DEPTH_LOG2-1:0] MEM_WADDR,
  output logic [31:0]           MEM_WDATA,
  output logic                  CPU_RST,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0] FULL_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_FINISH,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] len_m1_q, len_m1_d;
  logic [DEPTH_LOG2-1:0] wcnt_q, wcnt_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [23:0]           word_q, word_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [DEPTH_LOG2-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [DEPTH_LOG2:0]   len_map;

  // BYTE_READY is only ever high in LOAD, so this is the full handshake.
  assign accept = BYTE_VALID & byte_ready_q;

  always_comb begin
    len_map = LOAD_LEN;
    if (LOAD_LEN == '0 || LOAD_LEN > FULL_LEN) begin
      len_map = FULL_LEN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      len_m1_q     <= '0;
      wcnt_q       <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      tmo_q        <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_m1_q     <= len_m1_d;
      wcnt_q       <= wcnt_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      tmo_q        <= tmo_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_m1_d     = len_m1_q;
    wcnt_d       = wcnt_q;
    bidx_d       = bidx_q;
    word_d       = word_q;
    tmo_d        = tmo_q;
    byte_ready_d = byte_ready_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (state_q == S_IDLE) begin
          cpu_rst_d = 1'b0;
          busy_d    = 1'b0;
        end
        byte_ready_d = 1'b0;
        if (LOAD_START) begin
          // The first clear write is issued from this edge, so address 0
          // appears in the cycle right after LOAD_START.
          state_d     = S_CLEAR;
          len_m1_d    = DEPTH_LOG2'(len_map - 1'b1);
          wcnt_d      = '0;
          bidx_d      = '0;
          tmo_d       = '0;
          mem_we_d    = 1'b1;
          mem_waddr_d = '0;
          mem_wdata_d = NOP_WORD;
          cpu_rst_d   = 1'b1;
          busy_d      = 1'b1;
          err_d       = 1'b0;
        end
      end

      S_CLEAR: begin
        if (mem_waddr_q == '1) begin
          state_d      = S_LOAD;
          byte_ready_d = 1'b1;
        end else begin
          mem_we_d    = 1'b1;
          mem_waddr_d = mem_waddr_q + 1'b1;
          mem_wdata_d = NOP_WORD;
        end
      end

      S_LOAD: begin
        if (accept) begin
          tmo_d = '0;
          unique case (bidx_q)
            2'd0: word_d[7:0]   = BYTE_IN;
            2'd1: word_d[15:8]  = BYTE_IN;
            2'd2: word_d[23:16] = BYTE_IN;
            default: begin
              mem_we_d    = 1'b1;
              mem_waddr_d = wcnt_q;
              mem_wdata_d = {BYTE_IN, word_q};
              wcnt_d      = wcnt_q + 1'b1;
              if (wcnt_q == len_m1_q) begin
                state_d      = S_FINISH;
                byte_ready_d = 1'b0;
              end
            end
          endcase
          bidx_d = bidx_q + 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          // Any partially assembled word is discarded here.
          state_d      = S_ERROR;
          err_d        = 1'b1;
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
          bidx_d       = '0;
          tmo_d        = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_FINISH: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        cpu_rst_d = 1'b0;
        busy_d    = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign BYTE_READY = byte_ready_q;
  assign MEM_WE     = mem_we_q;
  assign MEM_WADDR  = mem_waddr_q;
  assign MEM_WDATA  = mem_wdata_q;
  assign CPU_RST    = cpu_rst_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
module tb_imem_load_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LOAD_START = 1'b0;
  logic [5:0]  LOAD_LEN = '0;
  logic [7:0]  BYTE_IN = '0;
  logic        BYTE_VALID = 1'b0;
  logic        BYTE_READY, MEM_WE, CPU_RST, BUSY, DONE, ERR;
  logic [4:0]  MEM_WADDR;
  logic [31:0] MEM_WDATA;

  imem_load_ctrl #(
    .DEPTH_LOG2(5),
    .NOP_WORD  (32'h00000013),
    .TIMEOUT   (16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOAD_START(LOAD_START),
    .LOAD_LEN  (LOAD_LEN),
    .BYTE_IN   (BYTE_IN),
    .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY),
    .MEM_WE    (MEM_WE),
    .MEM_WADDR (MEM_WADDR),
    .MEM_WDATA (MEM_WDATA),
    .CPU_RST   (CPU_RST),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        is_done;
    logic [4:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_write(input logic [4:0] a, input logic [31:0] d);
    ev_t e;
    e.is_done = 1'b0;
    e.addr    = a;
    e.data    = d;
    sb.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 32; i++) push_write(5'(i), NOP);
  endtask

  task automatic push_done();
    ev_t e;
    e.is_done = 1'b1;
    e.addr    = '0;
    e.data    = '0;
    sb.push_back(e);
  endtask

  // Monitor: pops one expected event per write or DONE the DUT presents.
  logic prev_we = 1'b0;
  always @(negedge CLK) begin
    ev_t e;
    if (!RST && (MEM_WE || DONE)) begin
      check("we_done_exclusive", MEM_WE & DONE, 0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got we=%0d done=%0d addr=%0d data=0x%08h required none", MEM_WE, DONE, MEM_WADDR, MEM_WDATA);
      end else begin
        e = sb.pop_front();
        check("event_kind", DONE, e.is_done);
        if (!e.is_done) begin
          check("waddr", MEM_WADDR, e.addr);
          check("wdata", MEM_WDATA, e.data);
          check("cpu_rst_during_write", CPU_RST, 1);
        end else begin
          check("done_after_last_write", prev_we, 1);
          check("cpu_rst_with_done", CPU_RST, 0);
          check("busy_with_done", BUSY, 0);
        end
      end
    end
    prev_we <= MEM_WE;
  end

  // Called at posedge+1; returns at posedge+1 of the edge after LOAD_START.
  task automatic start_load(input logic [5:0] len, output int t);
    LOAD_LEN   = len;
    LOAD_START = 1'b1;
    @(posedge CLK);
    #1;
    t = cyc;
    LOAD_START = 1'b0;
    @(negedge CLK);
    check("start_cpu_rst", CPU_RST, 1);
    check("start_busy", BUSY, 1);
    check("start_err_clear", ERR, 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    logic rdy;
    int   n;
    BYTE_VALID = 1'b0;
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
    BYTE_VALID = 1'b1;
    BYTE_IN    = b;
    n          = 0;
    acc        = -1;
    forever begin
      @(negedge CLK);
      rdy = BYTE_READY;
      @(posedge CLK);
      #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
      n++;
      if (n > 100) begin
        tests++;
        fails++;
        $display("FAIL byte_accept_timeout: got no accept for 0x%02h required accept", b);
        break;
      end
    end
    BYTE_VALID = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge CLK);
    check(name, sb.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic full_depth(input logic [5:0] len);
    int t, acc;
    logic ok;
    push_clear();
    for (int k = 0; k < 32; k++)
      push_write(5'(k), {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    push_done();
    start_load(len, t);
    for (int i = 0; i < 128; i++) send_byte(8'(i), 0, acc);
    drain("full_depth_drain");
    // A 129th byte must not be taken.
    BYTE_VALID = 1'b1;
    BYTE_IN    = 8'hAA;
    ok         = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      if (BYTE_READY) ok = 1'b0;
      @(posedge CLK);
      #1;
    end
    BYTE_VALID = 1'b0;
    check("no_129th_byte", ok, 1);
  endtask

  logic [7:0] t2b [8]  = '{8'h93, 8'h02, 8'h10, 8'h00, 8'h13, 8'h03, 8'h00, 8'h00};
  logic [7:0] t4b [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                           8'h99, 8'hAA, 8'hBB, 8'hCC};
  int         t4g [12] = '{0, 3, 5, 1, 0, 2, 4, 5, 0, 1, 3, 2};
  logic [7:0] t5b [6]  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02};
  logic [7:0] t5r [4]  = '{8'h37, 8'h05, 8'h00, 8'h80};

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int t, acc, first_acc, errc;
    logic got;

    // 1. reset and idle
    repeat (3) begin
      @(negedge CLK);
      check("rst_state", {CPU_RST, BUSY, MEM_WE, BYTE_READY}, 4'b1000);
      @(posedge CLK);
    end
    #1;
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("idle_state", {CPU_RST, BUSY, MEM_WE, BYTE_READY, DONE, ERR}, 6'b000000);
    @(posedge CLK);
    #1;

    // 2. two-word load
    push_clear();
    push_write(5'd0, 32'h00100293);
    push_write(5'd1, 32'h00000313);
    push_done();
    start_load(6'd2, t);
    first_acc = -1;
    for (int i = 0; i < 8; i++) begin
      send_byte(t2b[i], 0, acc);
      if (i == 0) first_acc = acc;
    end
    check("first_byte_latency", first_acc - t, 33);
    drain("two_word_drain");
    @(negedge CLK);
    check("after_done", {BYTE_READY, CPU_RST, BUSY}, 3'b000);
    @(posedge CLK);
    #1;

    // 3. full depth, LOAD_LEN=0 and a clamped oversize length
    full_depth(6'd0);
    full_depth(6'd45);

    // 4. gaps between bytes
    push_clear();
    push_write(5'd0, 32'h44332211);
    push_write(5'd1, 32'h88776655);
    push_write(5'd2, 32'hCCBBAA99);
    push_done();
    start_load(6'd3, t);
    for (int i = 0; i < 12; i++) send_byte(t4b[i], t4g[i], acc);
    drain("gaps_drain");
    check("gaps_no_err", ERR, 0);

    // 5. timeout with a partial word pending
    push_clear();
    push_write(5'd0, 32'hDEADBEEF);
    start_load(6'd2, t);
    for (int i = 0; i < 6; i++) send_byte(t5b[i], 0, acc);
    got  = 1'b0;
    errc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (ERR) begin
        got  = 1'b1;
        errc = cyc;
        break;
      end
    end
    check("err_seen", got, 1);
    check("err_latency", errc - acc, 16);
    check("err_state", {CPU_RST, BUSY, BYTE_READY}, 3'b100);
    check("timeout_drain", sb.size(), 0);
    @(posedge CLK);
    #1;
    push_clear();
    push_write(5'd0, 32'h80000537);
    push_done();
    start_load(6'd1, t);
    for (int i = 0; i < 4; i++) send_byte(t5r[i], 0, acc);
    drain("restart_drain");

    // 6. LOAD_START and RST during LOAD
    push_clear();
    push_write(5'd0, 32'hDEADBEEF);
    start_load(6'd4, t);
    for (int i = 0; i < 6; i++) send_byte(t5b[i], 0, acc);
    LOAD_LEN   = 6'd1;
    LOAD_START = 1'b1;
    @(posedge CLK);
    #1;
    LOAD_START = 1'b0;
    @(negedge CLK);
    check("start_ignored_in_load", {BUSY, CPU_RST, BYTE_READY, MEM_WE}, 4'b1110);
    @(negedge CLK);
    check("midload_drain", sb.size(), 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("midload_rst_outputs",
          {BYTE_READY, MEM_WE, MEM_WADDR, MEM_WDATA, CPU_RST, BUSY, DONE, ERR},
          {1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("idle_after_rst", {CPU_RST, BUSY, BYTE_READY, ERR}, 4'b0000);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
